control_unit: RTL and testbench

Finite-state controller that sequences the processor's fetch/decode/execute loop. It drives the instruction memory read, the instruction register load strobe, the PC controls, the data memory, the register file and the ALU. It decodes the 16-bit instruction currently held in the instruction register. It sits between the instruction register output and every datapath control input, and is the only block that asserts the `IR_ld` strobe.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/cu_decode.sv | 86 ++++++++
 rtl/control_unit.sv | 91 +++++++++
 tb/tb_control_unit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the processor control path.
//   opcode_t : 4-bit instruction opcodes held in IR[15:12]
//   state_t  : 4-bit controller state encodings (also shown on OutState)
//   ALU_*    : ALU operation select values driven on ALU_s0
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'h0,
    OP_STORE = 4'h1,
    OP_LOAD  = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_HALT  = 4'h5
  } opcode_t;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOADA  = 4'd4,
    S_LOADB  = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

endpackage

// File: rtl/cu_decode.sv
// Combinational output decode for the control unit (Moore outputs).
// Maps the current state and the instruction field split to the full
// datapath control bundle. Unused address outputs are driven to zero.
//   i_state  : current controller state
//   i_ir     : instruction register contents
//   o_*      : datapath controls, same meaning as the control_unit ports
module cu_decode
  import cpu_pkg::*;
#(
  parameter int AW = 8,
  parameter int RW = 4
) (
  input  state_t          i_state,
  input  logic [15:0]     i_ir,
  output logic            o_pc_clr,
  output logic            o_pc_up,
  output logic            o_im_rd,
  output logic            o_ir_ld,
  output logic [AW-1:0]   o_d_addr,
  output logic            o_d_wr,
  output logic            o_rf_s,
  output logic [RW-1:0]   o_rf_w_addr,
  output logic            o_rf_w_en,
  output logic [RW-1:0]   o_rf_ra_addr,
  output logic [RW-1:0]   o_rf_rb_addr,
  output logic [2:0]      o_alu_s0
);

  logic [AW-1:0] w_mem_addr;
  logic [RW-1:0] w_fld_hi;
  logic [RW-1:0] w_fld_mid;
  logic [RW-1:0] w_fld_lo;

  assign w_mem_addr = AW'(i_ir[11:4]);
  assign w_fld_hi   = RW'(i_ir[11:8]);
  assign w_fld_mid  = RW'(i_ir[7:4]);
  assign w_fld_lo   = RW'(i_ir[3:0]);

  always_comb begin
    o_pc_clr     = 1'b0;
    o_pc_up      = 1'b0;
    o_im_rd      = 1'b0;
    o_ir_ld      = 1'b0;
    o_d_addr     = '0;
    o_d_wr       = 1'b0;
    o_rf_s       = 1'b0;
    o_rf_w_addr  = '0;
    o_rf_w_en    = 1'b0;
    o_rf_ra_addr = '0;
    o_rf_rb_addr = '0;
    o_alu_s0     = ALU_PASS;
    unique case (i_state)
      S_INIT:  o_pc_clr = 1'b1;
      S_FETCH: begin
        o_im_rd = 1'b1;
        o_ir_ld = 1'b1;
        o_pc_up = 1'b1;
      end
      S_LOADA: begin
        o_d_addr = w_mem_addr;
        o_rf_s   = 1'b1;
      end
      // Address stays on the bus while the synchronous read data arrives.
      S_LOADB: begin
        o_d_addr    = w_mem_addr;
        o_rf_s      = 1'b1;
        o_rf_w_addr = w_fld_lo;
        o_rf_w_en   = 1'b1;
      end
      S_STORE: begin
        o_d_addr     = w_mem_addr;
        o_rf_ra_addr = w_fld_lo;
        o_d_wr       = 1'b1;
      end
      S_ADD, S_SUB: begin
        o_rf_ra_addr = w_fld_hi;
        o_rf_rb_addr = w_fld_mid;
        o_rf_w_addr  = w_fld_lo;
        o_rf_w_en    = 1'b1;
        o_alu_s0     = (i_state == S_ADD) ? ALU_ADD : ALU_SUB;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the processor datapath.
//   Clock, Reset (sync, active-high)     : clocking
//   IR                                   : current instruction
//   PC_clr, PC_up                        : program counter controls
//   IM_rd, IR_ld                         : instruction fetch controls
//   D_addr, D_wr                         : data memory controls
//   RF_s, RF_W_addr, RF_W_en,
//   RF_Ra_addr, RF_Rb_addr               : register file controls
//   ALU_s0                               : ALU operation select
//   OutState                             : encoded current state (debug)
module control_unit
  import cpu_pkg::*;
#(
  parameter int OPW = 4,
  parameter int AW  = 8,
  parameter int RW  = 4
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [15:0]     IR,
  output logic            PC_clr,
  output logic            PC_up,
  output logic            IM_rd,
  output logic            IR_ld,
  output logic [AW-1:0]   D_addr,
  output logic            D_wr,
  output logic            RF_s,
  output logic [RW-1:0]   RF_W_addr,
  output logic            RF_W_en,
  output logic [RW-1:0]   RF_Ra_addr,
  output logic [RW-1:0]   RF_Rb_addr,
  output logic [2:0]      ALU_s0,
  output logic [3:0]      OutState
);

  state_t  r_state;
  state_t  w_next;
  opcode_t w_op;

  assign w_op = opcode_t'(IR[15 -: OPW]);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_INIT:   w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (w_op)
          OP_STORE: w_next = S_STORE;
          OP_LOAD:  w_next = S_LOADA;
          OP_ADD:   w_next = S_ADD;
          OP_SUB:   w_next = S_SUB;
          OP_HALT:  w_next = S_HALT;
          default:  w_next = S_NOOP;
        endcase
      end
      S_NOOP, S_STORE, S_ADD, S_SUB, S_LOADB: w_next = S_FETCH;
      S_LOADA:  w_next = S_LOADB;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_INIT;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) r_state <= S_INIT;
    else       r_state <= w_next;
  end

  assign OutState = r_state;

  cu_decode #(
    .AW (AW),
    .RW (RW)
  ) u_decode (
    .i_state      (r_state),
    .i_ir         (IR),
    .o_pc_clr     (PC_clr),
    .o_pc_up      (PC_up),
    .o_im_rd      (IM_rd),
    .o_ir_ld      (IR_ld),
    .o_d_addr     (D_addr),
    .o_d_wr       (D_wr),
    .o_rf_s       (RF_s),
    .o_rf_w_addr  (RF_W_addr),
    .o_rf_w_en    (RF_W_en),
    .o_rf_ra_addr (RF_Ra_addr),
    .o_rf_rb_addr (RF_Rb_addr),
    .o_alu_s0     (ALU_s0)
  );

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the stimulus process pushes the
// expected output bundle for every cycle; a negedge monitor pops and compares.
module tb_control_unit;

  logic        Clock;
  logic        Reset;
  logic [15:0] IR;
  logic        PC_clr, PC_up, IM_rd, IR_ld, D_wr, RF_s, RF_W_en;
  logic [7:0]  D_addr;
  logic [3:0]  RF_W_addr, RF_Ra_addr, RF_Rb_addr, OutState;
  logic [2:0]  ALU_s0;

  control_unit #(
    .OPW (4),
    .AW  (8),
    .RW  (4)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .IR         (IR),
    .PC_clr     (PC_clr),
    .PC_up      (PC_up),
    .IM_rd      (IM_rd),
    .IR_ld      (IR_ld),
    .D_addr     (D_addr),
    .D_wr       (D_wr),
    .RF_s       (RF_s),
    .RF_W_addr  (RF_W_addr),
    .RF_W_en    (RF_W_en),
    .RF_Ra_addr (RF_Ra_addr),
    .RF_Rb_addr (RF_Rb_addr),
    .ALU_s0     (ALU_s0),
    .OutState   (OutState)
  );

  typedef struct packed {
    logic [3:0] st;
    logic       pc_clr;
    logic       pc_up;
    logic       im_rd;
    logic       ir_ld;
    logic [7:0] daddr;
    logic       d_wr;
    logic       rf_s;
    logic [3:0] waddr;
    logic       w_en;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] alu;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic exp_t mk(input logic [3:0] st, input logic pc_clr,
                              input logic pc_up, input logic im_rd,
                              input logic ir_ld, input logic [7:0] daddr,
                              input logic d_wr, input logic rf_s,
                              input logic [3:0] waddr, input logic w_en,
                              input logic [3:0] ra, input logic [3:0] rb,
                              input logic [2:0] alu);
    exp_t e;
    e = '{st, pc_clr, pc_up, im_rd, ir_ld, daddr, d_wr, rf_s, waddr, w_en, ra, rb, alu};
    return e;
  endfunction

  // Hand-written expected bundles, one per state flavour.
  function automatic exp_t e_init();
    return mk(4'd0, 1, 0, 0, 0, 8'h00, 0, 0, 4'd0, 0, 4'd0, 4'd0, 3'b000);
  endfunction
  function automatic exp_t e_fetch();
    return mk(4'd1, 0, 1, 1, 1, 8'h00, 0, 0, 4'd0, 0, 4'd0, 4'd0, 3'b000);
  endfunction
  function automatic exp_t e_quiet(input logic [3:0] st);
    return mk(st, 0, 0, 0, 0, 8'h00, 0, 0, 4'd0, 0, 4'd0, 4'd0, 3'b000);
  endfunction
  function automatic exp_t e_loada(input logic [7:0] a);
    return mk(4'd4, 0, 0, 0, 0, a, 0, 1, 4'd0, 0, 4'd0, 4'd0, 3'b000);
  endfunction
  function automatic exp_t e_loadb(input logic [7:0] a, input logic [3:0] w);
    return mk(4'd5, 0, 0, 0, 0, a, 0, 1, w, 1, 4'd0, 4'd0, 3'b000);
  endfunction
  function automatic exp_t e_store(input logic [7:0] a, input logic [3:0] ra);
    return mk(4'd6, 0, 0, 0, 0, a, 1, 0, 4'd0, 0, ra, 4'd0, 3'b000);
  endfunction
  function automatic exp_t e_alu(input logic [3:0] st, input logic [3:0] ra,
                                 input logic [3:0] rb, input logic [3:0] w,
                                 input logic [2:0] alu);
    return mk(st, 0, 0, 0, 0, 8'h00, 0, 0, w, 1, ra, rb, alu);
  endfunction

  task automatic tick(input exp_t e);
    @(posedge Clock);
    #1;
    q.push_back(e);
  endtask

  // Monitor: outputs are Moore, so the DUT presents a bundle every cycle.
  always @(negedge Clock) begin
    if (q.size() > 0) begin
      exp_t e, a;
      e = q.pop_front();
      a = '{OutState, PC_clr, PC_up, IM_rd, IR_ld, D_addr, D_wr, RF_s,
            RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s0};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL state%0d_bundle: actual=%h required=%h (t=%0t)",
                 e.st, a, e, $time);
      end
    end
  end

  initial begin
    Reset = 1'b1;
    IR    = 16'h0000;
    tick(e_init()); tick(e_init()); tick(e_init());
    Reset = 1'b0;
    tick(e_fetch());

    IR = 16'h2A35;  // LOAD
    tick(e_quiet(4'd2)); tick(e_loada(8'hA3)); tick(e_loadb(8'hA3, 4'd5));
    tick(e_fetch());

    IR = 16'h3123;  // ADD
    tick(e_quiet(4'd2)); tick(e_alu(4'd7, 4'd1, 4'd2, 4'd3, 3'b001));
    tick(e_fetch());

    IR = 16'h4123;  // SUB
    tick(e_quiet(4'd2)); tick(e_alu(4'd8, 4'd1, 4'd2, 4'd3, 3'b010));
    tick(e_fetch());

    IR = 16'h1F07;  // STORE
    tick(e_quiet(4'd2)); tick(e_store(8'hF0, 4'd7));
    tick(e_fetch());

    IR = 16'hF000;  // unused opcode -> NOOP
    tick(e_quiet(4'd2)); tick(e_quiet(4'd3));
    tick(e_fetch());

    IR = 16'h5000;  // HALT
    tick(e_quiet(4'd2));
    repeat (20) tick(e_quiet(4'd9));

    Reset = 1'b1;
    tick(e_init());
    Reset = 1'b0;
    tick(e_fetch());

    IR = 16'h2A35;  // LOAD aborted by reset in LoadA
    tick(e_quiet(4'd2)); tick(e_loada(8'hA3));
    Reset = 1'b1;
    tick(e_init());
    Reset = 1'b0;
    tick(e_fetch());

    IR = 16'h3123;
    tick(e_quiet(4'd2)); tick(e_alu(4'd7, 4'd1, 4'd2, 4'd3, 3'b001));
    tick(e_fetch());

    @(negedge Clock);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: actual=%0d required=0", q.size());
    end
    done = 1;
  end

  initial begin
    fork
      wait (done);
      begin
        #20000;
        failures++;
        $display("FAIL timeout: actual=running required=done");
      end
    join_any
    disable fork;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
